// File: rtl/julia_scan_ctrl_if.sv
// Pixel-sequencer bus: colour-engine drive/return and frame-buffer
// write port. Master side is the scan controller.
interface julia_scan_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic signed [31:0] calc_x;
  logic signed [31:0] calc_y;
  logic               calc_enable;
  logic               calc_end;
  logic [15:0]        calc_color;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [15:0]        fb_wdata;
  logic               fb_ready;

  modport master (
    output calc_x,
    output calc_y,
    output calc_enable,
    input  calc_end,
    input  calc_color,
    output fb_we,
    output fb_addr,
    output fb_wdata,
    input  fb_ready
  );

  modport slave (
    input  calc_x,
    input  calc_y,
    input  calc_enable,
    output calc_end,
    output calc_color,
    input  fb_we,
    input  fb_addr,
    input  fb_wdata,
    output fb_ready
  );
endinterface

// File: rtl/julia_scan_ctrl.sv
// Raster pixel sequencer for the Julia colour engine.
// Optional per-pixel watchdog: define JULIA_SCAN_TIMEOUT_EN.
module julia_scan_ctrl #(
  parameter int                 H_RES          = 320,
  parameter int                 V_RES          = 240,
  parameter int                 ADDR_W         = 17,
  parameter logic signed [31:0] X_MIN          = 32'shFE000000,
  parameter logic signed [31:0] Y_MAX          = 32'sh01800000,
  parameter logic signed [31:0] STEP           = 32'sh00033333,
  parameter int                 TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  julia_scan_ctrl_if.master  bus
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  localparam logic [15:0] TMO_COLOR = 16'h001F;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  if ((64'd1 << ADDR_W) < 64'(H_RES * V_RES)) begin : g_bad_aw
    $error("ADDR_W too narrow for H_RES*V_RES");
  end

  logic [2:0]         state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [ADDR_W-1:0]  addr;
  logic signed [31:0] cx;
  logic signed [31:0] cy;
  logic               cen;
  logic               we;
  logic [15:0]        wdata;
  logic               last;
  logic               tmo_hit;

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  assign bus.calc_x      = cx;
  assign bus.calc_y      = cy;
  assign bus.calc_enable = cen;
  assign bus.fb_we       = we;
  assign bus.fb_addr     = addr;
  assign bus.fb_wdata    = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cen   <= 1'b0;
      we    <= 1'b0;
      wdata <= '0;
      addr  <= '0;
      col   <= '0;
      row   <= '0;
      cx    <= X_MIN;
      cy    <= Y_MAX;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            addr  <= '0;
            col   <= '0;
            row   <= '0;
            cx    <= X_MIN;
            cy    <= Y_MAX;
          end
        end
        // engine latches cx/cy with enable low for this one cycle
        S_LOAD: begin
          cen   <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          if (bus.calc_end || tmo_hit) begin
            wdata <= bus.calc_end ? bus.calc_color : TMO_COLOR;
            cen   <= 1'b0;
            we    <= 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.fb_ready) begin
            we    <= 1'b0;
            state <= S_ADV;
          end
        end
        S_ADV: begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
            cx  <= X_MIN;
            cy  <= cy - STEP;
          end else begin
            col <= col + 1'b1;
            cx  <= cx + STEP;
          end
          // address parks on the final pixel rather than running past it
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef JULIA_SCAN_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tcnt;
  logic        tmo_err;

  assign tmo_hit = (state == S_RUN) && !bus.calc_end &&
                   (tcnt == TMO_LAST);
  assign timeout_err = tmo_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt    <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == S_LOAD)
        tcnt <= '0;
      else if (state == S_RUN)
        tcnt <= tcnt + 1'b1;

      if (state == S_IDLE && start)
        tmo_err <= 1'b0;
      else if (tmo_hit)
        tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_julia_scan_ctrl.sv
// Directed bench for julia_scan_ctrl on a 4x3 frame with a
// fixed-latency colour-engine model.
module tb_julia_scan_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int N  = H * V;
  localparam int AW = 4;
  localparam int TMO = 20;
  localparam logic signed [31:0] XM = 32'shFE000000;
  localparam logic signed [31:0] YM = 32'sh01800000;
  localparam logic signed [31:0] ST = 32'sh00033333;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic terr;

  julia_scan_ctrl_if #(.ADDR_W(AW)) bus ();

  julia_scan_ctrl #(
    .H_RES(H),
    .V_RES(V),
    .ADDR_W(AW),
    .X_MIN(XM),
    .Y_MAX(YM),
    .STEP(ST),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .timeout_err(terr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic eng_clr = 1'b0;
  logic stale_end = 1'b0;
  logic stall_on = 1'b0;
  int   hang_pix = -1;

  logic [3:0] ecnt = '0;
  logic       en_q = 1'b0;
  int cur_pix = 0;
  int next_pix = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int viol = 0;
  int scnt = 0;
  logic pw_q = 1'b0;
  logic [AW-1:0] pa_q = '0;
  logic [15:0]   pd_q = '0;

  logic [AW-1:0]      wr_addr [32];
  logic [15:0]        wr_data [32];
  logic signed [31:0] ld_x [32];
  logic signed [31:0] ld_y [32];

  assign bus.calc_end =
    (bus.calc_enable && ecnt >= 4'd5 && cur_pix != hang_pix) ||
    (stale_end && !bus.calc_enable);
  assign bus.calc_color = 16'(cur_pix);
  assign bus.fb_ready =
    !(stall_on && bus.fb_we && bus.fb_addr == 4'd5 && scnt < 7);

  always @(posedge clk) begin
    en_q <= bus.calc_enable;
    if (!bus.calc_enable) ecnt <= '0;
    else if (ecnt != 4'hF) ecnt <= ecnt + 4'd1;
    if (eng_clr) begin
      cur_pix  <= 0;
      next_pix <= 0;
      wr_cnt   <= 0;
      done_cnt <= 0;
      busy_cnt <= 0;
      viol     <= 0;
      scnt     <= 0;
      pw_q     <= 1'b0;
    end else begin
      if (bus.calc_enable && !en_q) begin
        cur_pix  <= next_pix;
        next_pix <= next_pix + 1;
        if (next_pix < 32) begin
          ld_x[next_pix] <= bus.calc_x;
          ld_y[next_pix] <= bus.calc_y;
        end
      end
      if (bus.fb_we && bus.fb_ready) begin
        if (wr_cnt < 32) begin
          wr_addr[wr_cnt] <= bus.fb_addr;
          wr_data[wr_cnt] <= bus.fb_wdata;
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      pw_q <= bus.fb_we && !bus.fb_ready;
      pa_q <= bus.fb_addr;
      pd_q <= bus.fb_wdata;
      if (pw_q && (!bus.fb_we || bus.fb_addr != pa_q ||
                   bus.fb_wdata != pd_q))
        viol <= viol + 1;
      if (bus.fb_we && bus.calc_enable) viol <= viol + 1;
      if (bus.fb_we && bus.fb_addr == 4'd5) scnt <= scnt + 1;
    end
  end

  task automatic clr();
    @(negedge clk) eng_clr = 1'b1;
    @(negedge clk) eng_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      $display("FAIL wait_done: no done after %0d cycles", budget);
      errors++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || terr !== 1'b0) begin
      $display("FAIL reset_flags: busy=%b done=%b terr=%b want 000",
               busy, done, terr);
      errors++;
    end
    checks++;
    if (bus.fb_we !== 1'b0 || bus.calc_enable !== 1'b0) begin
      $display("FAIL reset_en: fb_we=%b calc_enable=%b want 00",
               bus.fb_we, bus.calc_enable);
      errors++;
    end
    checks++;
    if (bus.calc_x !== XM || bus.calc_y !== YM) begin
      $display("FAIL reset_xy: got %h,%h want %h,%h",
               bus.calc_x, bus.calc_y, XM, YM);
      errors++;
    end
    checks++;
    if (bus.fb_addr !== 4'd0 || bus.fb_wdata !== 16'd0) begin
      $display("FAIL reset_fb: addr=%0d data=%h want 0,0",
               bus.fb_addr, bus.fb_wdata);
      errors++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    clr();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL frame_busy_on: busy=%b want 1", busy);
      errors++;
    end
    wait_done(1000);
    checks++;
    if (wr_cnt !== N) begin
      $display("FAIL frame_wr_cnt: got %0d want %0d", wr_cnt, N);
      errors++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== 16'(i)) begin
        $display("FAIL frame_wr[%0d]: addr=%0d data=%h want %0d,%h",
                 i, wr_addr[i], wr_data[i], i, 16'(i));
        errors++;
      end
    end
    checks++;
    if (done_cnt !== 1 || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL frame_end: done_cnt=%0d done=%b busy=%b want 1,0,0",
               done_cnt, done, busy);
      errors++;
    end
    checks++;
    if (busy_cnt !== N * 9) begin
      $display("FAIL frame_busy_cycles: got %0d want %0d",
               busy_cnt, N * 9);
      errors++;
    end
`ifndef JULIA_SCAN_TIMEOUT_EN
    checks++;
    if (terr !== 1'b0) begin
      $display("FAIL frame_terr: got %b want 0", terr);
      errors++;
    end
`endif
  endtask

  task automatic test_coords();
    logic signed [31:0] ex;
    logic signed [31:0] ey;
    clr();
    pulse_start();
    wait_done(1000);
    checks++;
    if (next_pix !== N) begin
      $display("FAIL coord_loads: got %0d want %0d", next_pix, N);
      errors++;
    end
    checks++;
    if (ld_x[0] !== 32'shFE000000 || ld_y[0] !== 32'sh01800000) begin
      $display("FAIL coord_p0: got %h,%h want fe000000,01800000",
               ld_x[0], ld_y[0]);
      errors++;
    end
    checks++;
    if (ld_x[3] !== 32'shFE099999 || ld_y[3] !== 32'sh01800000) begin
      $display("FAIL coord_p3: got %h,%h want fe099999,01800000",
               ld_x[3], ld_y[3]);
      errors++;
    end
    checks++;
    if (ld_x[4] !== 32'shFE000000 || ld_y[4] !== 32'sh017CCCCD) begin
      $display("FAIL coord_p4: got %h,%h want fe000000,017ccccd",
               ld_x[4], ld_y[4]);
      errors++;
    end
    for (int i = 0; i < N; i++) begin
      ex = XM + (i % H) * ST;
      ey = YM - (i / H) * ST;
      checks++;
      if (ld_x[i] !== ex || ld_y[i] !== ey) begin
        $display("FAIL coord[%0d]: got %h,%h want %h,%h",
                 i, ld_x[i], ld_y[i], ex, ey);
        errors++;
      end
    end
  endtask

  task automatic test_stall();
    clr();
    stall_on = 1'b1;
    pulse_start();
    wait_done(1000);
    stall_on = 1'b0;
    checks++;
    if (viol !== 0) begin
      $display("FAIL stall_stable: violations=%0d want 0", viol);
      errors++;
    end
    checks++;
    if (scnt !== 8) begin
      $display("FAIL stall_hold: fb_we cycles on addr5=%0d want 8", scnt);
      errors++;
    end
    checks++;
    if (wr_cnt !== N || next_pix !== N) begin
      $display("FAIL stall_cnt: writes=%0d loads=%0d want %0d,%0d",
               wr_cnt, next_pix, N, N);
      errors++;
    end
    checks++;
    if (wr_addr[5] !== 4'd5 || wr_data[5] !== 16'd5) begin
      $display("FAIL stall_px5: addr=%0d data=%h want 5,0005",
               wr_addr[5], wr_data[5]);
      errors++;
    end
    checks++;
    if (busy_cnt !== N * 9 + 7) begin
      $display("FAIL stall_busy_cycles: got %0d want %0d",
               busy_cnt, N * 9 + 7);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clr();
    pulse_start();
    while (!(cur_pix == 6 && bus.calc_enable) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(cur_pix == 6 && bus.calc_enable)) begin
      $display("FAIL rstmid_reach: pixel 6 RUN not seen, cur=%0d",
               cur_pix);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fb_we !== 1'b0 || bus.calc_enable !== 1'b0 ||
        busy !== 1'b0) begin
      $display("FAIL rstmid_out: we=%b en=%b busy=%b want 000",
               bus.fb_we, bus.calc_enable, busy);
      errors++;
    end
    checks++;
    if (bus.fb_addr !== 4'd0 || bus.calc_x !== XM) begin
      $display("FAIL rstmid_state: addr=%0d x=%h want 0,%h",
               bus.fb_addr, bus.calc_x, XM);
      errors++;
    end
    rst = 1'b0;
    clr();
    pulse_start();
    wait_done(1000);
    checks++;
    if (wr_cnt !== N || wr_addr[0] !== 4'd0 || wr_data[0] !== 16'd0) begin
      $display("FAIL rstmid_restart: n=%0d a0=%0d d0=%h want %0d,0,0",
               wr_cnt, wr_addr[0], wr_data[0], N);
      errors++;
    end
    checks++;
    if (wr_addr[N-1] !== 4'd11 || wr_data[N-1] !== 16'd11) begin
      $display("FAIL rstmid_last: addr=%0d data=%h want 11,000b",
               wr_addr[N-1], wr_data[N-1]);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    clr();
    stale_end = 1'b1;
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (13) @(negedge clk);
    pulse_start();
    wait_done(1000);
    stale_end = 1'b0;
    checks++;
    if (wr_cnt !== N || done_cnt !== 1) begin
      $display("FAIL b2b_counts: writes=%0d dones=%0d want %0d,1",
               wr_cnt, done_cnt, N);
      errors++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== 16'(i)) begin
        $display("FAIL b2b_wr[%0d]: addr=%0d data=%h want %0d,%h",
                 i, wr_addr[i], wr_data[i], i, 16'(i));
        errors++;
      end
    end
    checks++;
    if (busy_cnt !== N * 9) begin
      $display("FAIL b2b_busy_cycles: got %0d want %0d",
               busy_cnt, N * 9);
      errors++;
    end
    clr();
    pulse_start();
    wait_done(1000);
    checks++;
    if (wr_cnt !== N || wr_data[7] !== 16'd7) begin
      $display("FAIL b2b_second: writes=%0d d7=%h want %0d,0007",
               wr_cnt, wr_data[7], N);
      errors++;
    end
  endtask

`ifdef JULIA_SCAN_TIMEOUT_EN
  task automatic test_timeout();
    clr();
    hang_pix = 2;
    pulse_start();
    wait_done(2000);
    hang_pix = -1;
    checks++;
    if (wr_addr[2] !== 4'd2 || wr_data[2] !== 16'h001F) begin
      $display("FAIL tmo_px2: addr=%0d data=%h want 2,001f",
               wr_addr[2], wr_data[2]);
      errors++;
    end
    checks++;
    if (terr !== 1'b1) begin
      $display("FAIL tmo_flag: got %b want 1", terr);
      errors++;
    end
    checks++;
    if (wr_cnt !== N || wr_data[3] !== 16'd3 ||
        wr_data[11] !== 16'd11) begin
      $display("FAIL tmo_rest: n=%0d d3=%h d11=%h want %0d,0003,000b",
               wr_cnt, wr_data[3], wr_data[11], N);
      errors++;
    end
    checks++;
    if (busy_cnt !== (N - 1) * 9 + 23) begin
      $display("FAIL tmo_busy_cycles: got %0d want %0d",
               busy_cnt, (N - 1) * 9 + 23);
      errors++;
    end
    clr();
    pulse_start();
    checks++;
    if (terr !== 1'b0) begin
      $display("FAIL tmo_clear: got %b want 0", terr);
      errors++;
    end
    wait_done(1000);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_coords();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef JULIA_SCAN_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
